// File: rtl/fetch_buffer_if.sv
// Instruction-memory channel between the fetch unit and imem.
//   req_valid / req_addr / req_ready : valid/ready fetch request, word address
//   rsp_valid / rsp_data             : valid-only response, strictly in request order
// master = fetch unit, slave = instruction memory.
interface fetch_buffer_if;
   logic        req_valid;
   logic [31:0] req_addr;
   logic        req_ready;
   logic        rsp_valid;
   logic [31:0] rsp_data;

   modport master (
      output req_valid, req_addr,
      input  req_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  req_valid, req_addr,
      output req_ready, rsp_valid, rsp_data
   );
endinterface

// File: rtl/fetch_buffer.sv
// Front-end fetch unit. Owns the fetch PC, issues in-order requests to imem,
// queues returned instructions with their PC and trace ID in a DEPTH-entry FIFO
// and presents the head to decode. A flush (commit-time taken branch) empties
// the FIFO, marks all in-flight responses stale and redirects the fetch PC.
// Ports:
//   clk_i, rstn_i      clock, asynchronous active-low reset
//   flush_i, new_pc_i  redirect request and target
//   stall_i            decode holds the head entry
//   imem               request/response channel (master side)
//   pc_o, instr_o, valid_o, kanata_id_o   FIFO head presented to decode
module fetch_buffer #(
   parameter int unsigned DEPTH     = 4,
   parameter logic [31:0] RESET_PC  = 32'h0000_1000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  flush_i,
   input  logic [31:0]           new_pc_i,
   input  logic                  stall_i,
   fetch_buffer_if.master        imem,
   output logic [31:0]           pc_o,
   output logic [31:0]           instr_o,
   output logic                  valid_o,
   output logic [31:0]           kanata_id_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

   logic [31:0]   pc_mem_q    [DEPTH];
   logic [31:0]   instr_mem_q [DEPTH];
   logic [31:0]   id_mem_q    [DEPTH];

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] outstanding_q, outstanding_d;
   logic [CW-1:0] discard_q, discard_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   // PC of the oldest non-stale in-flight request. Requests are sequential
   // between redirects and a redirect makes everything in flight stale, so a
   // single register stands in for a full PC shadow queue.
   logic [31:0]   rsp_pc_q, rsp_pc_d;
   logic [31:0]   next_id_q, next_id_d;

   logic [CW:0]   inflight;
   logic          req_fire;
   logic          push;
   logic          pop;

   // Every in-flight request owns a FIFO slot, so a response always has room.
   always_comb begin
      inflight       = {1'b0, outstanding_q} + {1'b0, count_q};
      imem.req_valid = rstn_i && (inflight < DEPTH_W);
      imem.req_addr  = fetch_pc_q;
   end

   always_comb begin
      req_fire = imem.req_valid & imem.req_ready;
      push     = imem.rsp_valid & ~flush_i & (discard_q == '0);
      pop      = valid_o & ~stall_i & ~flush_i;
   end

   always_comb begin
      outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem.rsp_valid);
      discard_d     = discard_q;
      count_d       = count_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      fetch_pc_d    = fetch_pc_q;
      rsp_pc_d      = rsp_pc_q;
      next_id_d     = next_id_q;

      if (push) begin
         next_id_d = next_id_q + 32'd1;
      end

      if (flush_i) begin
         // Everything still in flight after this edge belongs to the old path,
         // including a request fired in this very cycle.
         discard_d  = outstanding_d;
         count_d    = '0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         fetch_pc_d = new_pc_i;
         rsp_pc_d   = new_pc_i;
      end else begin
         if (imem.rsp_valid && (discard_q != '0)) begin
            discard_d = discard_q - CW'(1);
         end
         count_d = count_q + CW'(push) - CW'(pop);
         if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            rsp_pc_d = rsp_pc_q + 32'd4;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         if (req_fire) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         outstanding_q <= '0;
         discard_q     <= '0;
         fetch_pc_q    <= RESET_PC;
         rsp_pc_q      <= RESET_PC;
         next_id_q     <= '0;
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
         fetch_pc_q    <= fetch_pc_d;
         rsp_pc_q      <= rsp_pc_d;
         next_id_q     <= next_id_d;
      end
   end

   // Payload storage needs no reset; it is only visible while count_q > 0.
   always_ff @(posedge clk_i) begin
      if (push) begin
         pc_mem_q[wr_ptr_q]    <= rsp_pc_q;
         instr_mem_q[wr_ptr_q] <= imem.rsp_data;
         id_mem_q[wr_ptr_q]    <= next_id_q;
      end
   end

   always_comb begin
      valid_o     = (count_q != '0);
      pc_o        = 32'd0;
      instr_o     = NOP_INSTR;
      kanata_id_o = 32'd0;
      if (valid_o) begin
         pc_o        = pc_mem_q[rd_ptr_q];
         instr_o     = instr_mem_q[rd_ptr_q];
         kanata_id_o = id_mem_q[rd_ptr_q];
      end
   end

endmodule

// File: tb/tb_fetch_buffer.sv
module tb_fetch_buffer;

   logic        clk_i;
   logic        rstn_i;
   logic        flush_i;
   logic [31:0] new_pc_i;
   logic        stall_i;
   logic [31:0] pc_o;
   logic [31:0] instr_o;
   logic        valid_o;
   logic [31:0] kanata_id_o;

   fetch_buffer_if imem_bus ();

   fetch_buffer dut (
      .clk_i       (clk_i),
      .rstn_i      (rstn_i),
      .flush_i     (flush_i),
      .new_pc_i    (new_pc_i),
      .stall_i     (stall_i),
      .imem        (imem_bus),
      .pc_o        (pc_o),
      .instr_o     (instr_o),
      .valid_o     (valid_o),
      .kanata_id_o (kanata_id_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Inputs are applied for one cycle; expected outputs are those visible
   // during that cycle, before the following rising edge.
   typedef struct {
      logic        rdy;
      logic        rsp;
      logic [31:0] data;
      logic        stall;
      logic        flush;
      logic [31:0] npc;
      logic        e_rv;
      logic [31:0] e_addr;
      logic        e_v;
      logic [31:0] e_pc;
      logic [31:0] e_ins;
      logic [31:0] e_id;
   } vec_t;

   vec_t tbl[$];
   int   total = 0;
   int   bad   = 0;

   localparam logic [31:0] NOP = 32'h0000_0013;

   function automatic vec_t mk(logic rdy, logic rsp, logic [31:0] data, logic stall,
                               logic flush, logic [31:0] npc, logic e_rv,
                               logic [31:0] e_addr, logic e_v, logic [31:0] e_pc,
                               logic [31:0] e_ins, logic [31:0] e_id);
      vec_t v;
      v.rdy = rdy; v.rsp = rsp; v.data = data; v.stall = stall; v.flush = flush;
      v.npc = npc; v.e_rv = e_rv; v.e_addr = e_addr; v.e_v = e_v; v.e_pc = e_pc;
      v.e_ins = e_ins; v.e_id = e_id;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic rdy, input logic rsp, input logic [31:0] data,
                        input logic stall, input logic flush, input logic [31:0] npc);
      imem_bus.req_ready = rdy;
      imem_bus.rsp_valid = rsp;
      imem_bus.rsp_data  = data;
      stall_i            = stall;
      flush_i            = flush;
      new_pc_i           = npc;
   endtask

   initial begin
      //          rdy rsp data          stl fl  npc            rv  addr           v   pc             ins            id
      tbl.push_back(mk(1, 0, 32'h0,       0, 0, 32'h0,       1, 32'h1000,     0, 32'h0,        NOP,           32'd0)); // 0
      tbl.push_back(mk(1, 1, 32'hA0,      0, 0, 32'h0,       1, 32'h1004,     0, 32'h0,        NOP,           32'd0)); // 1
      tbl.push_back(mk(1, 1, 32'hA1,      0, 0, 32'h0,       1, 32'h1008,     1, 32'h1000,     32'hA0,        32'd0)); // 2
      tbl.push_back(mk(1, 1, 32'hA2,      1, 0, 32'h0,       1, 32'h100C,     1, 32'h1004,     32'hA1,        32'd1)); // 3
      tbl.push_back(mk(1, 1, 32'hA3,      1, 0, 32'h0,       1, 32'h1010,     1, 32'h1004,     32'hA1,        32'd1)); // 4
      tbl.push_back(mk(1, 1, 32'hA4,      1, 0, 32'h0,       0, 32'h1014,     1, 32'h1004,     32'hA1,        32'd1)); // 5 full reservation
      tbl.push_back(mk(1, 0, 32'h0,       1, 0, 32'h0,       0, 32'h1014,     1, 32'h1004,     32'hA1,        32'd1)); // 6 fifo full
      tbl.push_back(mk(0, 0, 32'h0,       0, 0, 32'h0,       0, 32'h1014,     1, 32'h1004,     32'hA1,        32'd1)); // 7 drain
      tbl.push_back(mk(0, 0, 32'h0,       0, 0, 32'h0,       1, 32'h1014,     1, 32'h1008,     32'hA2,        32'd2)); // 8 ready low
      tbl.push_back(mk(0, 0, 32'h0,       1, 0, 32'h0,       1, 32'h1014,     1, 32'h100C,     32'hA3,        32'd3)); // 9 addr held
      tbl.push_back(mk(1, 0, 32'h0,       1, 0, 32'h0,       1, 32'h1014,     1, 32'h100C,     32'hA3,        32'd3)); // 10
      tbl.push_back(mk(1, 0, 32'h0,       1, 1, 32'h2000,    1, 32'h1018,     1, 32'h100C,     32'hA3,        32'd3)); // 11 flush + fire
      tbl.push_back(mk(0, 1, 32'hB0,      0, 0, 32'h0,       1, 32'h2000,     0, 32'h0,        NOP,           32'd0)); // 12 stale drop
      tbl.push_back(mk(1, 1, 32'hB1,      0, 0, 32'h0,       1, 32'h2000,     0, 32'h0,        NOP,           32'd0)); // 13 stale drop
      tbl.push_back(mk(0, 1, 32'hC0,      0, 0, 32'h0,       1, 32'h2004,     0, 32'h0,        NOP,           32'd0)); // 14 new path
      tbl.push_back(mk(0, 0, 32'h0,       0, 0, 32'h0,       1, 32'h2004,     1, 32'h2000,     32'hC0,        32'd5)); // 15
      tbl.push_back(mk(1, 0, 32'h0,       0, 0, 32'h0,       1, 32'h2004,     0, 32'h0,        NOP,           32'd0)); // 16
      tbl.push_back(mk(1, 1, 32'hC1,      0, 1, 32'h3000,    1, 32'h2008,     0, 32'h0,        NOP,           32'd0)); // 17 flush+rsp+fire
      tbl.push_back(mk(1, 1, 32'hD0,      0, 0, 32'h0,       1, 32'h3000,     0, 32'h0,        NOP,           32'd0)); // 18 stale drop
      tbl.push_back(mk(0, 1, 32'hE0,      0, 0, 32'h0,       1, 32'h3004,     0, 32'h0,        NOP,           32'd0)); // 19
      tbl.push_back(mk(0, 0, 32'h0,       1, 0, 32'h0,       1, 32'h3004,     1, 32'h3000,     32'hE0,        32'd6)); // 20
      tbl.push_back(mk(1, 0, 32'h0,       1, 1, 32'hFFFF_FFFC, 1, 32'h3004,   1, 32'h3000,     32'hE0,        32'd6)); // 21 flush to top
      tbl.push_back(mk(1, 1, 32'hF0,      1, 0, 32'h0,       1, 32'hFFFF_FFFC, 0, 32'h0,       NOP,           32'd0)); // 22
      tbl.push_back(mk(1, 1, 32'hF1,      1, 0, 32'h0,       1, 32'h0,        0, 32'h0,        NOP,           32'd0)); // 23 pc wrapped
      tbl.push_back(mk(1, 1, 32'hF2,      1, 0, 32'h0,       1, 32'h4,        1, 32'hFFFF_FFFC, 32'hF1,       32'd7)); // 24
      tbl.push_back(mk(0, 1, 32'hF3,      1, 0, 32'h0,       1, 32'h8,        1, 32'hFFFF_FFFC, 32'hF1,       32'd7)); // 25
      tbl.push_back(mk(0, 0, 32'h0,       1, 0, 32'h0,       1, 32'h8,        1, 32'hFFFF_FFFC, 32'hF1,       32'd7)); // 26 3 queued

      rstn_i = 1'b0;
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      #2;
      check("rst_req_valid", {31'd0, imem_bus.req_valid}, 32'd0);
      check("rst_valid",     {31'd0, valid_o},            32'd0);
      check("rst_pc",        pc_o,                        32'd0);
      check("rst_instr",     instr_o,                     NOP);
      check("rst_id",        kanata_id_o,                 32'd0);
      @(negedge clk_i);
      @(negedge clk_i);
      rstn_i = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].rdy, tbl[i].rsp, tbl[i].data, tbl[i].stall, tbl[i].flush, tbl[i].npc);
         #1;
         check($sformatf("v%0d_req_valid", i), {31'd0, imem_bus.req_valid}, {31'd0, tbl[i].e_rv});
         check($sformatf("v%0d_req_addr", i),  imem_bus.req_addr,           tbl[i].e_addr);
         check($sformatf("v%0d_valid", i),     {31'd0, valid_o},            {31'd0, tbl[i].e_v});
         check($sformatf("v%0d_pc", i),        pc_o,                        tbl[i].e_pc);
         check($sformatf("v%0d_instr", i),     instr_o,                     tbl[i].e_ins);
         check($sformatf("v%0d_id", i),        kanata_id_o,                 tbl[i].e_id);
         @(negedge clk_i);
      end

      // Mid-stream reset with three entries queued: outputs clear at once.
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      #1;
      check("pre_rst_valid", {31'd0, valid_o}, 32'd1);
      rstn_i = 1'b0;
      #1;
      check("mid_rst_valid",     {31'd0, valid_o},            32'd0);
      check("mid_rst_req_valid", {31'd0, imem_bus.req_valid}, 32'd0);
      check("mid_rst_pc",        pc_o,                        32'd0);
      check("mid_rst_instr",     instr_o,                     NOP);
      @(negedge clk_i);
      rstn_i = 1'b1;
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      #1;
      check("restart_req_valid", {31'd0, imem_bus.req_valid}, 32'd1);
      check("restart_addr",      imem_bus.req_addr,           32'h1000);
      check("restart_valid",     {31'd0, valid_o},            32'd0);
      @(negedge clk_i);
      drive(1'b1, 1'b1, 32'h9A, 1'b0, 1'b0, 32'h0);
      #1;
      check("restart_addr2", imem_bus.req_addr, 32'h1004);
      @(negedge clk_i);
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      #1;
      check("restart_head_valid", {31'd0, valid_o}, 32'd1);
      check("restart_head_pc",    pc_o,             32'h1000);
      check("restart_head_instr", instr_o,          32'h9A);
      check("restart_head_id",    kanata_id_o,      32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Front-end fetch unit feeding the decode register of the in-order RISC-V pipeline.
- Owns the fetch PC and issues in-order requests to instruction memory over a valid/ready request channel plus a valid-only response channel.
- Queues returned instructions with their PC and Kanata trace ID in a small FIFO, presented to decode.
- Commit-time taken branches flush the FIFO, discard in-flight responses and redirect the PC.

Parameters:
- DEPTH, 4, FIFO entries and maximum in-flight requests; power of two, ≥2.
- RESET_PC, 32'h0000_1000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0013, value driven on instr_o when the FIFO is empty.

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-low
- flush_i  in  1  commit taken branch; redirect to new_pc_i
- new_pc_i  in  32  redirect target
- stall_i  in  1  decode not accepting; hold the head entry
- imem_req_valid_o  out  1  fetch request valid
- imem_req_addr_o  out  32  fetch address (word aligned)
- imem_req_ready_i  in  1  imem accepts the request
- imem_rsp_valid_i  in  1  response valid; in order, one per accepted request
- imem_rsp_data_i  in  32  instruction word
- pc_o  out  32  head PC
- instr_o  out  32  head instruction
- valid_o  out  1  head valid
- kanata_id_o  out  32  head trace ID

Behaviour:
- Reset (async): fetch_pc=RESET_PC, FIFO empty, outstanding=0, discard=0, next_id=0. Outputs: valid_o=0, pc_o=0, instr_o=NOP_INSTR, kanata_id_o=0, imem_req_valid_o=0 while rstn_i low.
- Request rule:
  - imem_req_valid_o = (outstanding + count < DEPTH). This reserves a FIFO slot for every in-flight request, so the FIFO never overflows.
  - imem_req_addr_o = fetch_pc.
  - Request fire = valid & ready. On fire: fetch_pc += 4 (mod 2^32, wraps), outstanding += 1.
  - Valid is held until accepted, unless flush_i rises.
- Response:
  - imem_rsp_valid_i decrements outstanding.
  - If discard>0: response dropped, discard -= 1.
  - Else: push {pc, data, next_id}; next_id += 1. The entry PC comes from an internal in-order PC shadow queue, or equivalently the head-of-flight PC register.
- Output/pop:
  - valid_o = count>0; head fields are driven combinationally from the FIFO head.
  - When empty: pc_o=0, instr_o=NOP_INSTR, kanata_id_o=0.
  - Pop when valid_o & ~stall_i. Push and pop in the same cycle leave count unchanged.
- Flush (flush_i=1, highest priority):
  - FIFO emptied.
  - fetch_pc <= new_pc_i.
  - discard <= outstanding + req_fire − rsp_valid − (1 if discard>0 and rsp_valid, already counted).
  - Net rule: every request accepted on or before the flush cycle whose response has not arrived is discarded. A response arriving in the flush cycle is dropped and never pushed.
  - A request fired in the flush cycle carries the old PC and counts as stale.
  - No pop occurs in the flush cycle.
  - next_id is not reset, so IDs stay unique for the trace.
  - First new request is issued the cycle after flush_i.
- Simultaneous events:
  - Response while count==DEPTH cannot occur, because slots are reserved.
  - Flush overrides push, pop and fetch_pc increment.
- Reset mid-operation: all state cleared immediately. Responses returning after reset are an integration error; imem shares the reset.
- Latency: response at cycle N (not discarded) is visible on valid_o at N+1. Minimum redirect-to-valid latency = 1 + imem latency + 1.

Test Plan:
- Reset release, imem ready=1, 1-cycle latency, stall_i=0 → requests 0x1000, 0x1004, 0x1008…; valid_o from cycle 3 with pc_o 0x1000, kanata_id_o 0,1,2 in order.
- stall_i=1 for 10 cycles → FIFO fills to 4, imem_req_valid_o drops with outstanding+count=4, head stays pc 0x1000. Release → entries drain in order, no loss.
- imem_req_ready_i low 3 cycles → addr_o held at 0x1008, valid held; no PC skip.
- With 2 in flight (3-cycle latency), flush_i with new_pc_i=0x2000 → FIFO empty next cycle, two stale responses dropped, next valid_o has pc_o 0x2000, kanata_id_o continues from last+1.
- flush_i in the same cycle as a response and a request fire → both stale; no entry from the old path appears.
- Assert rstn_i low mid-stream with 3 entries queued → valid_o=0, imem_req_valid_o=0 asynchronously; after release, fetch restarts at 0x1000, id 0.
